// File: rtl/hack_rom_loader_if.sv
// Signal bundle between the Hack boot loader, the UART receiver/host side,
// the instruction ROM write port and the CPU reset input.
`timescale 1ns/1ps
interface hack_rom_loader_if #(
  parameter int ADDR_W = 15
);
  logic              load;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              cpu_reset;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              busy;
  logic              err;

  modport master (
    output load, rx_valid, rx_data,
    input  cpu_reset, rom_we, rom_addr, rom_wdata, busy, err
  );

  modport slave (
    input  load, rx_valid, rx_data,
    output cpu_reset, rom_we, rom_addr, rom_wdata, busy, err
  );
endinterface

// File: rtl/hack_rom_loader.sv
// Boot/program-load controller for the Hack CPU: parses a length-prefixed
// big-endian byte stream into 16-bit words, writes them to ROM from address 0.
`timescale 1ns/1ps
module hack_rom_loader #(
  parameter int ADDR_W     = 15,
  parameter int TIMEOUT    = 1000000,
  parameter bit START_LOAD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  hack_rom_loader_if.slave bus
);

  localparam int          CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE, RUN} state_t;
  localparam state_t RST_STATE = START_LOAD ? LEN_HI : RUN;

  state_t            state, state_n;
  logic [15:0]       len, len_n;
  logic [7:0]        hi, hi_n;
  logic [ADDR_W:0]   addr, addr_n;
  logic [CNT_W-1:0]  idle, idle_n;
  logic              we, we_n;
  logic [ADDR_W-1:0] waddr, waddr_n;
  logic [15:0]       wdata, wdata_n;
  logic              err, err_n;
  logic              cpu_rst, busy;
  logic              timed;
  logic [15:0]       n_rx;
  logic              last_word;

  always_comb begin
    state_n   = state;
    len_n     = len;
    hi_n      = hi;
    addr_n    = addr;
    we_n      = 1'b0;
    waddr_n   = waddr;
    wdata_n   = wdata;
    err_n     = err;
    timed     = (state == LEN_LO) || (state == DATA_HI) || (state == DATA_LO);
    n_rx      = {len[15:8], bus.rx_data};
    last_word = (17'(addr) == {1'b0, len - 16'd1});

    // load beats any byte arriving in the same cycle
    if (bus.load) begin
      state_n = LEN_HI;
      addr_n  = '0;
    end else if (bus.rx_valid) begin
      unique case (state)
        LEN_HI: begin
          len_n[15:8] = bus.rx_data;
          state_n     = LEN_LO;
        end
        LEN_LO: begin
          len_n[7:0] = bus.rx_data;
          if (n_rx == 16'd0 || {1'b0, n_rx} > DEPTH) begin
            err_n   = 1'b1;
            state_n = LEN_HI;
          end else begin
            addr_n  = '0;
            state_n = DATA_HI;
          end
        end
        DATA_HI: begin
          hi_n    = bus.rx_data;
          state_n = DATA_LO;
        end
        DATA_LO: begin
          we_n    = 1'b1;
          waddr_n = addr[ADDR_W-1:0];
          wdata_n = {hi, bus.rx_data};
          if (last_word) begin
            err_n   = 1'b0;
            state_n = DONE;
          end else begin
            addr_n  = addr + 1'b1;
            state_n = DATA_HI;
          end
        end
        DONE:    state_n = RUN;
        default: state_n = state;
      endcase
    end else if (state == DONE) begin
      state_n = RUN;
    end else if (timed && idle == CNT_W'(TIMEOUT - 1)) begin
      err_n   = 1'b1;
      state_n = LEN_HI;
    end

    if (!timed || bus.rx_valid || state_n != state) idle_n = '0;
    else                                            idle_n = idle + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RST_STATE;
      len     <= '0;
      hi      <= '0;
      addr    <= '0;
      idle    <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      err     <= 1'b0;
      cpu_rst <= 1'b1;
      busy    <= START_LOAD;
    end else begin
      state   <= state_n;
      len     <= len_n;
      hi      <= hi_n;
      addr    <= addr_n;
      idle    <= idle_n;
      we      <= we_n;
      waddr   <= waddr_n;
      wdata   <= wdata_n;
      err     <= err_n;
      cpu_rst <= (state_n != RUN);
      busy    <= (state_n != RUN);
    end
  end

  assign bus.cpu_reset = cpu_rst;
  assign bus.rom_we    = we;
  assign bus.rom_addr  = waddr;
  assign bus.rom_wdata = wdata;
  assign bus.busy      = busy;
  assign bus.err       = err;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Scoreboard bench for hack_rom_loader: expected ROM writes are queued from the
// program being sent; a monitor pops and compares on every rom_we.
`timescale 1ns/1ps
module tb_hack_rom_loader;
  localparam int AW = 4;
  localparam int TO = 20;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hack_rom_loader_if #(.ADDR_W(AW)) bus ();
  hack_rom_loader_if #(.ADDR_W(AW)) bus_b ();

  hack_rom_loader #(.ADDR_W(AW), .TIMEOUT(TO), .START_LOAD(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  hack_rom_loader #(.ADDR_W(AW), .TIMEOUT(TO), .START_LOAD(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  int n_cmp = 0;
  int n_bad = 0;
  wr_t exp_q[$];
  logic [15:0] prog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.rom_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%04h, want no write at %0t",
                 bus.rom_addr, bus.rom_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("rom_addr", 32'(bus.rom_addr), e.addr);
        check("rom_wdata", 32'(bus.rom_wdata), e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap(input bit b2b);
    if (!b2b) repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic expect_write(input int a, input logic [15:0] d);
    wr_t e;
    e.addr = 32'(a);
    e.data = 32'(d);
    exp_q.push_back(e);
  endtask

  task automatic pulse_load();
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("load_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("load_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(16'($urandom));
  endtask

  // Sends prog as a complete transfer; the model is simply "word i lands at addr i".
  task automatic run_program(input bit b2b);
    logic [15:0] n;
    n = 16'(prog.size());
    for (int i = 0; i < prog.size(); i++) expect_write(i, prog[i]);
    gap(b2b);
    send_byte(n[15:8]);
    gap(b2b);
    send_byte(n[7:0]);
    for (int i = 0; i < prog.size(); i++) begin
      logic [15:0] w;
      w = prog[i];
      gap(b2b);
      send_byte(w[15:8]);
      gap(b2b);
      send_byte(w[7:0]);
    end
    check("done_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("done_rom_we", 32'(bus.rom_we), 32'd1);
    tick();
    check("run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("run_busy", 32'(bus.busy), 32'd0);
    check("run_err", 32'(bus.err), 32'd0);
    check("writes_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_bad_len(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    tick();
    check("badlen_err", 32'(bus.err), 32'd1);
    check("badlen_busy", 32'(bus.busy), 32'd1);
    check("badlen_cpu_reset", 32'(bus.cpu_reset), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    bus.load = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    bus_b.load = 1'b0; bus_b.rx_valid = 1'b0; bus_b.rx_data = 8'h00;
    #1 reset = 1'b1;
    #11;
    check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("rst_rom_we", 32'(bus.rom_we), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_rom_wdata", 32'(bus.rom_wdata), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_b_cpu_reset", 32'(bus_b.cpu_reset), 32'd1);
    check("rst_b_busy", 32'(bus_b.busy), 32'd0);
    @(negedge clk) reset = 1'b0;
    tick();
    check("b_cpu_reset_released", 32'(bus_b.cpu_reset), 32'd0);
    check("a_cpu_reset_held", 32'(bus.cpu_reset), 32'd1);

    // basic load straight out of reset
    prog = {16'h1234, 16'hABCD, 16'hFF00};
    run_program(1'b0);

    // reload from RUN
    pulse_load();
    rand_prog(1);
    run_program(1'b0);

    // zero length, then a valid transfer from LEN_HI clears err
    pulse_load();
    send_bad_len(16'h0000);
    rand_prog(1);
    run_program(1'b0);

    // oversize length, then exactly DEPTH words
    pulse_load();
    send_bad_len(16'h0011);
    rand_prog(16);
    run_program(1'b0);

    // timeout after one word of two
    pulse_load();
    send_byte(8'h00);
    send_byte(8'h02);
    expect_write(0, 16'h1122);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (19) tick();
    check("timeout_not_yet", 32'(bus.err), 32'd0);
    tick();
    check("timeout_err", 32'(bus.err), 32'd1);
    check("timeout_busy", 32'(bus.busy), 32'd1);
    check("timeout_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("timeout_pending", 32'(exp_q.size()), 32'd0);
    rand_prog(2);
    run_program(1'b1);

    // load collides with a low byte
    pulse_load();
    send_byte(8'h00);
    send_byte(8'h02);
    expect_write(0, 16'h0A0B);
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h0C);
    bus.load = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h0D;
    tick();
    bus.load = 1'b0;
    bus.rx_valid = 1'b0;
    check("collide_no_we", 32'(bus.rom_we), 32'd0);
    prog = {16'h5566};
    run_program(1'b1);

    // async reset between the bytes of the second word
    pulse_load();
    send_byte(8'h00);
    send_byte(8'h02);
    expect_write(0, 16'h7788);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'hAA;
    #2 reset = 1'b1;
    #1;
    check("arst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("arst_rom_we", 32'(bus.rom_we), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.rx_valid = 1'b0;
    check("arst_rom_we_held", 32'(bus.rom_we), 32'd0);
    check("arst_b_cpu_reset", 32'(bus_b.cpu_reset), 32'd1);
    @(negedge clk) reset = 1'b0;
    rand_prog(2);
    run_program(1'b0);

    tick();
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
